dircc_node_mem_initiator: RTL and testbench
===========================================

DIRCC_NODE_MEM_INITIATOR -- requirements
Module: dircc_node_mem_initiator

Interface
REQ-001 The block SHALL have these parameters: ADDR_W, default 14, word-address width; DATA_W, default 32, data width; MEM_WORDS, default 10240, memory depth in words; RD_FIFO_DEPTH, default 4, read buffer depth (power of 2, at least 2).
REQ-002 The block SHALL have these ports, listed as name  direction  width  meaning:
- clk  in  1  single clock; all logic rises on posedge clk.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  block-transfer command offered.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write block, 0 = read block.
- cmd_addr  in  ADDR_W  start word address.
- cmd_len  in  ADDR_W+1  word count.
- wr_valid, wr_ready, wr_data  in/out/in  1/1/DATA_W  write-data stream.
- rd_valid, rd_ready, rd_data  out/in/out  1/1/DATA_W  read-data stream.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse when a command is rejected (REQ-017).
- avm_address  out  ADDR_W  memory word address.
- avm_byteenable  out  DATA_W/8  byte enables; always all ones.
- avm_chipselect, avm_write  out  1/1  access strobes.
- avm_writedata  out  DATA_W  write data.
- avm_readdata  in  DATA_W  read data; valid exactly 1 cycle after a read strobe.
- avm_clken  out  1  memory clock enable; held at 1 outside reset.

Function
REQ-003 The FSM SHALL have states IDLE, WRITE, READ, DRAIN and DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-004 On command accept, the block SHALL latch address and length; if length is 0 it SHALL go to DONE, else to WRITE when cmd_write is 1, else to READ.
REQ-005 In WRITE, wr_ready SHALL be 1 combinationally, and each wr_valid cycle SHALL drive avm_chipselect=1, avm_write=1, avm_writedata=wr_data, avm_address=current address in that same cycle.
REQ-006 The address SHALL increment by 1 per access and wrap from MEM_WORDS-1 to 0.
REQ-007 The remaining-word count SHALL decrement per access; after the last write the FSM SHALL enter DONE.
REQ-008 In READ, a read strobe (avm_chipselect=1, avm_write=0) SHALL issue only when FIFO occupancy plus in-flight reads is less than RD_FIFO_DEPTH.
REQ-009 avm_readdata SHALL be pushed into the read FIFO on the cycle after each read strobe; the first rd_valid SHALL occur no earlier than 2 cycles after accept.
REQ-010 After the last read is issued, the FSM SHALL enter DRAIN, and SHALL leave DRAIN for DONE once the FIFO is empty and no read is in flight.
REQ-011 rd_valid SHALL equal FIFO non-empty; a pop SHALL occur on rd_valid and rd_ready; a simultaneous push and pop SHALL be legal at full and at empty.
REQ-012 DONE SHALL last 1 cycle with done=1, then return to IDLE; the next command SHALL be accepted no earlier than the following cycle.
REQ-013 Outside WRITE, wr_ready SHALL be 0; avm_chipselect and avm_write SHALL be 0 whenever no access issues.

Reset
REQ-014 While reset_n=0 at posedge clk: FSM SHALL go to IDLE; FIFO, counters and the in-flight flag SHALL clear; cmd_ready SHALL be 0; done, err, rd_valid, wr_ready, avm_chipselect, avm_write and avm_clken SHALL be 0; avm_address SHALL be 0.
REQ-015 Reset mid-transfer SHALL abort it with no done pulse and SHALL discard buffered read data.
REQ-016 On the first cycle after reset release, cmd_ready SHALL be 1.

Configuration
REQ-017 With DIRCC_NODE_MEM_INITIATOR_BOUNDS_EN defined, a command with cmd_addr >= MEM_WORDS or cmd_len > MEM_WORDS SHALL be accepted, SHALL produce no memory access, and SHALL pulse err for 1 cycle, returning to IDLE with no done pulse.
REQ-018 Without DIRCC_NODE_MEM_INITIATOR_BOUNDS_EN, no check SHALL exist, err SHALL be tied to 0, and addresses SHALL wrap per REQ-006.

Structure
REQ-019 Package dircc_node_mem_pkg SHALL hold the FSM state enum and the default ADDR_W, DATA_W and MEM_WORDS constants.
REQ-020 The read buffer SHALL be the sub-module dircc_node_mem_rd_fifo, a synchronous FIFO with valid/ready on both sides.

Verification
REQ-021 Write cmd addr=0x10, len=4 with wr_valid held high -> 4 consecutive writes at 0x10..0x13, done pulse 1 cycle after the last write.
REQ-022 Read cmd addr=0x10, len=4 with rd_ready=1 -> rd_data matches the previously written words in order, then 1 done pulse.
REQ-023 Read len=8 with rd_ready=0 for 20 cycles -> exactly 4 strobes issue and then stall; on releasing rd_ready, all 8 words arrive with none lost or duplicated.
REQ-024 Write addr=10238, len=4 -> accesses at 10238, 10239, 0, 1 (bounds macro off); with the macro on, addr=10240 -> err pulse and no strobe.
REQ-025 cmd len=0 -> done 1 cycle after accept and no strobe; reset_n low during word 3 of a len=8 read -> rd_valid=0 next cycle, no done pulse, cmd_ready=1 after release.

Source files
------------

// File: rtl/dircc_node_mem_pkg.sv
// Shared definitions for the DIRCC node memory initiator.
// Holds the controller state encoding and the default geometry constants
// used as parameter defaults by dircc_node_mem_initiator.
package dircc_node_mem_pkg;

  localparam int unsigned DefaultAddrW    = 14;
  localparam int unsigned DefaultDataW    = 32;
  localparam int unsigned DefaultMemWords = 10240;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/dircc_node_mem_rd_fifo.sv
// Synchronous read-data buffer for the DIRCC node memory initiator.
// Valid/ready on both sides; a push and a pop in the same cycle are legal at full
// (the pop frees the slot) and at empty (the pop is simply not offered).
// Ports:
//   clk, reset_n               clock, synchronous active-low reset
//   i_wr_valid/o_wr_ready/i_wr_data   push side
//   o_rd_valid/i_rd_ready/o_rd_data   pop side
//   o_count                    current occupancy
module dircc_node_mem_rd_fifo
  import dircc_node_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_wr_valid,
  output logic                     o_wr_ready,
  input  logic [DATA_W-1:0]        i_wr_data,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic [DATA_W-1:0]        o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  assign w_full     = (r_count == CntW'(DEPTH));
  assign w_empty    = (r_count == '0);
  // At full, a same-cycle pop makes room for the push.
  assign o_wr_ready = !w_full || i_rd_ready;
  assign o_rd_valid = !w_empty;
  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign w_push     = i_wr_valid && o_wr_ready;
  assign w_pop      = o_rd_valid && i_rd_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/dircc_node_mem_initiator.sv
// Block-transfer initiator for a DIRCC node's local word memory.
// Accepts a (write/read, start address, length) command, then streams words
// between the write/read data ports and an Avalon-style on-chip memory with a
// fixed one-cycle read latency. Read data is buffered in dircc_node_mem_rd_fifo;
// reads are only issued while buffer space (including the read in flight) remains.
// Optional build macro: DIRCC_NODE_MEM_INITIATOR_BOUNDS_EN rejects commands whose
// start address or length exceed the memory, pulsing err instead of accessing it.
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len   command handshake
//   wr_valid/wr_ready/wr_data         write-data stream into the block
//   rd_valid/rd_ready/rd_data         read-data stream out of the block
//   done, err                         completion / rejection pulses
//   avm_*                             memory-side master interface
module dircc_node_mem_initiator
  import dircc_node_mem_pkg::*;
#(
  parameter int unsigned ADDR_W        = DefaultAddrW,
  parameter int unsigned DATA_W        = DefaultDataW,
  parameter int unsigned MEM_WORDS     = DefaultMemWords,
  parameter int unsigned RD_FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [ADDR_W:0]     cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic                avm_clken
);

  localparam int unsigned CntW = $clog2(RD_FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MEM_WORDS - 1);
  localparam logic [ADDR_W:0]   OneWord  = {{ADDR_W{1'b0}}, 1'b1};

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_next;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W:0]   r_remain;
  logic [ADDR_W:0]   w_remain_next;
  logic              r_rd_inflight;
  logic              w_wr_strobe;
  logic              w_rd_strobe;
  logic              w_cmd_bad;
  logic [CntW-1:0]   w_fifo_count;
  logic [CntW:0]     w_rd_credit;
  logic              w_fifo_wr_ready;
  logic              w_fifo_rd_valid;
  logic              w_push;

`ifdef DIRCC_NODE_MEM_INITIATOR_BOUNDS_EN
  logic r_err;

  assign w_cmd_bad = (32'(cmd_addr) >= MEM_WORDS) || (32'(cmd_len) > MEM_WORDS);

  // A rejected command is consumed in IDLE; err fires the following cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) r_err <= 1'b0;
    else          r_err <= (r_state == StIdle) && cmd_valid && w_cmd_bad;
  end

  assign err = reset_n && r_err;
`else
  assign w_cmd_bad = 1'b0;
  assign err       = 1'b0;
`endif

  // Explicit wrap: MEM_WORDS need not be a power of two.
  assign w_addr_inc  = (r_addr == LastAddr) ? '0 : r_addr + 1'b1;
  // Occupancy plus the read whose data lands next cycle.
  assign w_rd_credit = {1'b0, w_fifo_count} + {{CntW{1'b0}}, r_rd_inflight};

  always_comb begin
    w_state_next  = r_state;
    w_addr_next   = r_addr;
    w_remain_next = r_remain;
    w_wr_strobe   = 1'b0;
    w_rd_strobe   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (cmd_valid && !w_cmd_bad) begin
          w_addr_next   = cmd_addr;
          w_remain_next = cmd_len;
          if (cmd_len == '0)  w_state_next = StDone;
          else if (cmd_write) w_state_next = StWrite;
          else                w_state_next = StRead;
        end
      end
      StWrite: begin
        if (wr_valid) begin
          w_wr_strobe   = 1'b1;
          w_addr_next   = w_addr_inc;
          w_remain_next = r_remain - OneWord;
          if (r_remain == OneWord) w_state_next = StDone;
        end
      end
      StRead: begin
        if (w_rd_credit < (CntW + 1)'(RD_FIFO_DEPTH)) begin
          w_rd_strobe   = 1'b1;
          w_addr_next   = w_addr_inc;
          w_remain_next = r_remain - OneWord;
          if (r_remain == OneWord) w_state_next = StDrain;
        end
      end
      StDrain: begin
        if ((w_fifo_count == '0) && !r_rd_inflight) w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= StIdle;
      r_addr        <= '0;
      r_remain      <= '0;
      r_rd_inflight <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_addr        <= w_addr_next;
      r_remain      <= w_remain_next;
      r_rd_inflight <= w_rd_strobe;
    end
  end

  // Credit check guarantees space, so the ready term never actually drops data.
  assign w_push = r_rd_inflight && w_fifo_wr_ready;

  dircc_node_mem_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_wr_valid (w_push),
    .o_wr_ready (w_fifo_wr_ready),
    .i_wr_data  (avm_readdata),
    .o_rd_valid (w_fifo_rd_valid),
    .i_rd_ready (rd_ready),
    .o_rd_data  (rd_data),
    .o_count    (w_fifo_count)
  );

  // Handshake outputs are forced low while reset is asserted.
  assign cmd_ready      = reset_n && (r_state == StIdle);
  assign wr_ready       = reset_n && (r_state == StWrite);
  assign rd_valid       = reset_n && w_fifo_rd_valid;
  assign done           = reset_n && (r_state == StDone);
  assign avm_chipselect = reset_n && (w_wr_strobe || w_rd_strobe);
  assign avm_write      = reset_n && w_wr_strobe;
  assign avm_address    = r_addr;
  assign avm_writedata  = wr_data;
  assign avm_byteenable = '1;
  assign avm_clken      = reset_n;

endmodule

// File: tb/tb_dircc_node_mem_initiator.sv
// Directed bench for dircc_node_mem_initiator with a one-cycle-latency memory model.
module tb_dircc_node_mem_initiator;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          done, err;
  logic [AW-1:0] avm_address;
  logic [3:0]    avm_byteenable;
  logic          avm_chipselect, avm_write, avm_clken;
  logic [DW-1:0] avm_writedata;
  logic [DW-1:0] avm_readdata = '0;

  dircc_node_mem_initiator u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .done           (done),
    .err            (err),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_clken      (avm_clken)
  );

  always #5 clk = ~clk;

  // Memory slave: read data valid the cycle after the strobe.
  logic [DW-1:0] mem [0:16383];
  always @(posedge clk) begin
    if (avm_chipselect && avm_clken) begin
      if (avm_write) mem[avm_address] <= avm_writedata;
      else           avm_readdata     <= mem[avm_address];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor at the falling edge, away from the active edge.
  int            acc_cyc;
  int            n_done = 0;
  int            done_cyc;
  int            n_errp = 0;
  int            st_cyc[$];
  logic          st_wr[$];
  logic [AW-1:0] st_addr[$];
  logic [DW-1:0] st_data[$];
  logic [DW-1:0] rx[$];
  int            rx_cyc[$];

  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) acc_cyc <= cyc;
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (err) n_errp <= n_errp + 1;
    if (avm_chipselect) begin
      st_cyc.push_back(cyc);
      st_wr.push_back(avm_write);
      st_addr.push_back(avm_address);
      st_data.push_back(avm_writedata);
    end
    if (rd_valid && rd_ready) begin
      rx.push_back(rd_data);
      rx_cyc.push_back(cyc);
    end
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    st_cyc.delete(); st_wr.delete(); st_addr.delete(); st_data.delete();
    rx.delete(); rx_cyc.delete();
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [AW:0] l);
    check("cmd_ready_before_issue", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic write_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + DW'(i);
      step(1);
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int snap, input int max);
    int k = 0;
    while (n_done == snap && k < max) begin
      step(1);
      k++;
    end
    check(tag, (n_done > snap), 1'b1);
  endtask

  int snap;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

    // Reset state.
    step(3);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_strobes", {done, err, rd_valid, wr_ready, avm_chipselect, avm_write}, 6'b0);
    check("rst_clken", avm_clken, 1'b0);
    check("rst_address", avm_address, 14'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1'b1);
    check("post_rst_clken", avm_clken, 1'b1);
    check("byteenable", avm_byteenable, 4'hF);
    step(1);

    // Write 0x10, len 4, wr_valid held high.
    clear_logs();
    snap = n_done;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 14'h10; cmd_len = 15'd4;
    step(1);
    cmd_valid = 1'b0;
    write_words(32'hA000_0000, 4);
    wait_done("wr_done_seen", snap, 20);
    step(2);
    check("wr_strobe_cnt", st_addr.size(), 4);
    for (int i = 0; i < 4 && i < st_addr.size(); i++) begin
      check("wr_addr", st_addr[i], 14'h10 + 14'(i));
      check("wr_data", st_data[i], 32'hA000_0000 + 32'(i));
      check("wr_is_write", st_wr[i], 1'b1);
      check("wr_cycle", st_cyc[i] - acc_cyc, i + 1);
    end
    check("wr_done_cnt", n_done - snap, 1);
    if (st_cyc.size() == 4) check("wr_done_latency", done_cyc - st_cyc[3], 1);

    // Read 0x10, len 4, rd_ready high.
    clear_logs();
    snap = n_done;
    rd_ready = 1'b1;
    issue(1'b0, 14'h10, 15'd4);
    wait_done("rd_done_seen", snap, 40);
    step(2);
    check("rd_word_cnt", rx.size(), 4);
    for (int i = 0; i < 4 && i < rx.size(); i++)
      check("rd_data", rx[i], 32'hA000_0000 + 32'(i));
    if (rx_cyc.size() > 0) check("rd_first_latency_ge2", (rx_cyc[0] - acc_cyc) >= 2, 1'b1);
    check("rd_strobe_cnt", st_addr.size(), 4);
    check("rd_done_cnt", n_done - snap, 1);

    // Fill 0x20..0x27 for the backpressure read.
    snap = n_done;
    issue(1'b1, 14'h20, 15'd8);
    write_words(32'hB000_0000, 8);
    wait_done("fill_done_seen", snap, 20);
    step(1);

    // Read len 8 with rd_ready low for 20 cycles.
    clear_logs();
    snap = n_done;
    rd_ready = 1'b0;
    issue(1'b0, 14'h20, 15'd8);
    step(20);
    check("bp_strobe_cnt", st_addr.size(), 4);
    check("bp_rd_valid", rd_valid, 1'b1);
    check("bp_no_done", n_done - snap, 0);
    rd_ready = 1'b1;
    wait_done("bp_done_seen", snap, 60);
    step(2);
    check("bp_word_cnt", rx.size(), 8);
    for (int i = 0; i < 8 && i < rx.size(); i++)
      check("bp_data", rx[i], 32'hB000_0000 + 32'(i));
    check("bp_total_strobes", st_addr.size(), 8);
    for (int i = 0; i < st_addr.size(); i++) begin
      check("bp_addr", st_addr[i], 14'h20 + 14'(i));
      check("bp_is_read", st_wr[i], 1'b0);
    end

    // Wrap: 10238 len 4 -> 10238, 10239, 0, 1.
    clear_logs();
    snap = n_done;
    issue(1'b1, 14'd10238, 15'd4);
    write_words(32'hC000_0000, 4);
    wait_done("wrap_done_seen", snap, 20);
    step(1);
    check("wrap_cnt", st_addr.size(), 4);
    if (st_addr.size() == 4) begin
      check("wrap_a0", st_addr[0], 14'd10238);
      check("wrap_a1", st_addr[1], 14'd10239);
      check("wrap_a2", st_addr[2], 14'd0);
      check("wrap_a3", st_addr[3], 14'd1);
    end

    // Zero-length command.
    clear_logs();
    snap = n_done;
    issue(1'b0, 14'h30, 15'd0);
    step(3);
    check("len0_done_cnt", n_done - snap, 1);
    check("len0_done_latency", done_cyc - acc_cyc, 1);
    check("len0_no_strobe", st_addr.size(), 0);

`ifdef DIRCC_NODE_MEM_INITIATOR_BOUNDS_EN
    // Out-of-range start address.
    clear_logs();
    snap = n_done;
    issue(1'b1, 14'd10240, 15'd2);
    wr_valid = 1'b1;
    step(4);
    wr_valid = 1'b0;
    check("oob_err_cnt", n_errp, 1);
    check("oob_no_strobe", st_addr.size(), 0);
    check("oob_no_done", n_done - snap, 0);
    check("oob_cmd_ready", cmd_ready, 1'b1);
`else
    check("no_err_pulses", n_errp, 0);
`endif

    // Reset during word 3 of a len-8 read.
    clear_logs();
    snap = n_done;
    rd_ready = 1'b1;
    issue(1'b0, 14'h20, 15'd8);
    for (int k = 0; k < 40 && rx.size() < 2; k++) step(1);
    check("mid_rx_before_reset", rx.size(), 2);
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rd_valid_in_reset", rd_valid, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_cmd_ready_after", cmd_ready, 1'b1);
    check("mid_rd_valid_after", rd_valid, 1'b0);
    clear_logs();
    step(10);
    check("mid_no_done", n_done - snap, 0);
    check("mid_no_strobe_after", st_addr.size(), 0);
    check("mid_no_data_after", rx.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
